hud_lives: RTL and testbench

Heads-up-display stage that draws the player's remaining lives as a row of heart sprites and tracks the lives count. It sits directly upstream of the combinational heart sprite ROM. Each pixel it converts raw scan coordinates into sprite-local `heart_x`, `heart_y` and `heart_en`, then registers the returned `heart_data` as `pixel_on` for the colour mixer. It also owns the lives counter, the game-over flag and the blink animation of a just-lost heart.

---
 rtl/hud_lives.sv | 168 ++++++++++++++++
 tb/tb_hud_lives.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/hud_lives.sv
// Heart-row HUD stage: maps scan coordinates to heart sprite ROM lookups, registers the
// returned pixel, and owns the lives counter, game-over flag and lost-heart blink.
module hud_lives #(
  parameter int unsigned MAX_LIVES     = 5,
  parameter int unsigned START_LIVES   = 3,
  parameter int unsigned HUD_X0        = 8,
  parameter int unsigned HUD_Y0        = 8,
  parameter int unsigned BLINK_FRAMES  = 8,
  parameter int unsigned BLINK_TOGGLES = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       video_on,
  input  logic       frame_tick,
  input  logic       life_lost,
  input  logic       life_gain,
  input  logic       game_reset,
  output logic [3:0] heart_x,
  output logic [3:0] heart_y,
  output logic       heart_en,
  input  logic       heart_data,
  output logic       pixel_on,
  output logic [2:0] lives,
  output logic       game_over
);

  localparam int unsigned FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned TCNT_W = $clog2(BLINK_TOGGLES + 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BLINK = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [2:0]          r_lives;
  logic [2:0]          w_lives_nxt;
  logic                r_game_over;
  logic                w_game_over_nxt;
  logic [2:0]          r_blink_idx;
  logic [2:0]          w_blink_idx_nxt;
  logic                r_blink_vis;
  logic                w_blink_vis_nxt;
  logic [FCNT_W-1:0]   r_fcnt;
  logic [FCNT_W-1:0]   w_fcnt_nxt;
  logic [TCNT_W-1:0]   r_tcnt;
  logic [TCNT_W-1:0]   w_tcnt_nxt;
  logic                r_pixel_on;

  logic [9:0] w_dx;
  logic [9:0] w_dy;
  logic [5:0] w_slot;
  logic       w_in_region;
  logic       w_slot_lit;
  logic       w_lost_ok;
  logic       w_gain_ok;
  logic [2:0] w_lives_dec;
  logic [2:0] w_lives_inc;

  // Sprite-local coordinates; the 16-px pitch makes the slot the upper bits of dx.
  assign w_dx   = pixel_x - 10'(HUD_X0);
  assign w_dy   = pixel_y - 10'(HUD_Y0);
  assign w_slot = w_dx[9:4];

  assign w_in_region = (pixel_x >= 10'(HUD_X0)) && (pixel_y >= 10'(HUD_Y0)) &&
                       (w_dy < 10'd15) && (w_dx[3:0] != 4'hF) &&
                       (w_slot < 6'(MAX_LIVES));

  assign w_slot_lit = (w_slot < {3'b000, r_lives}) ||
                      ((r_state == ST_BLINK) && (w_slot == {3'b000, r_blink_idx}) && r_blink_vis);

  assign heart_x  = w_dx[3:0];
  assign heart_y  = w_dy[3:0];
  assign heart_en = video_on & w_in_region & w_slot_lit;

  // Pulses only count when not masked by a new game, game over or a simultaneous opposite pulse.
  assign w_lost_ok   = life_lost & ~life_gain & ~r_game_over & ~game_reset;
  assign w_gain_ok   = life_gain & ~life_lost & ~r_game_over & ~game_reset;
  assign w_lives_dec = r_lives - 3'd1;
  assign w_lives_inc = ({1'b0, r_lives} >= 4'(MAX_LIVES)) ? r_lives : (r_lives + 3'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_lives_nxt     = r_lives;
    w_game_over_nxt = r_game_over;
    w_blink_idx_nxt = r_blink_idx;
    w_blink_vis_nxt = r_blink_vis;
    w_fcnt_nxt      = r_fcnt;
    w_tcnt_nxt      = r_tcnt;

    if (game_reset) begin
      w_state_nxt     = ST_IDLE;
      w_lives_nxt     = 3'(START_LIVES);
      w_game_over_nxt = 1'b0;
    end else if (w_lost_ok) begin
      // A hit always (re)starts the blink on the slot just emptied.
      w_state_nxt     = ST_BLINK;
      w_lives_nxt     = w_lives_dec;
      w_game_over_nxt = (w_lives_dec == 3'd0);
      w_blink_idx_nxt = w_lives_dec;
      w_blink_vis_nxt = 1'b0;
      w_fcnt_nxt      = '0;
      w_tcnt_nxt      = '0;
    end else if (w_gain_ok) begin
      w_state_nxt = ST_IDLE;
      w_lives_nxt = w_lives_inc;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_IDLE;
        end
        ST_BLINK: begin
          if (frame_tick) begin
            if (r_fcnt == FCNT_W'(BLINK_FRAMES - 1)) begin
              w_fcnt_nxt      = '0;
              w_blink_vis_nxt = ~r_blink_vis;
              w_tcnt_nxt      = r_tcnt + TCNT_W'(1);
              if (r_tcnt == TCNT_W'(BLINK_TOGGLES - 1)) begin
                w_state_nxt = ST_IDLE;
              end
            end else begin
              w_fcnt_nxt = r_fcnt + FCNT_W'(1);
            end
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lives     <= 3'(START_LIVES);
      r_game_over <= 1'b0;
      r_blink_idx <= 3'd0;
      r_blink_vis <= 1'b0;
      r_fcnt      <= '0;
      r_tcnt      <= '0;
      r_pixel_on  <= 1'b0;
    end else begin
      r_lives     <= w_lives_nxt;
      r_game_over <= w_game_over_nxt;
      r_blink_idx <= w_blink_idx_nxt;
      r_blink_vis <= w_blink_vis_nxt;
      r_fcnt      <= w_fcnt_nxt;
      r_tcnt      <= w_tcnt_nxt;
      r_pixel_on  <= heart_data;
    end
  end

  assign lives     = r_lives;
  assign game_over = r_game_over;
  assign pixel_on  = r_pixel_on;

endmodule

// File: tb/tb_hud_lives.sv
// Randomized self-checking bench for hud_lives against a frame-count reference model,
// with a small combinational heart ROM stand-in.
module tb_hud_lives;

  localparam int MAX_LIVES     = 5;
  localparam int START_LIVES   = 3;
  localparam int HUD_X0        = 8;
  localparam int HUD_Y0        = 8;
  localparam int BLINK_FRAMES  = 8;
  localparam int BLINK_TOGGLES = 6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       video_on;
  logic       frame_tick;
  logic       life_lost;
  logic       life_gain;
  logic       game_reset;
  logic [3:0] heart_x;
  logic [3:0] heart_y;
  logic       heart_en;
  logic       heart_data;
  logic       pixel_on;
  logic [2:0] lives;
  logic       game_over;

  always #5 clk = ~clk;

  hud_lives dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .video_on   (video_on),
    .frame_tick (frame_tick),
    .life_lost  (life_lost),
    .life_gain  (life_gain),
    .game_reset (game_reset),
    .heart_x    (heart_x),
    .heart_y    (heart_y),
    .heart_en   (heart_en),
    .heart_data (heart_data),
    .pixel_on   (pixel_on),
    .lives      (lives),
    .game_over  (game_over)
  );

  // Stand-in sprite ROM: any fixed non-trivial pattern gated by enable.
  function automatic logic rom_f(input int x, input int y, input int en);
    return (en != 0) && (((x + y) % 3) != 0);
  endfunction

  assign heart_data = rom_f(int'(heart_x), int'(heart_y), int'(heart_en));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: lives, game over, and blink as "ticks elapsed since the hit".
  int m_lives = 0;
  int m_go    = 0;
  int m_blink = 0;
  int m_t     = 0;
  int m_idx   = 0;
  int m_valid = 0;
  int exp_pix = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle(input int rn, input int px, input int py, input int vo,
                       input int ft, input int ll, input int lg, input int gr);
    int dx, dy, slot, inreg, lit, een, ex, ey, vis, nxt_pix, lost_ok, gain_ok;
    @(negedge clk);
    if (m_valid != 0) begin
      check_eq("lives", int'(lives), m_lives);
      check_eq("game_over", int'(game_over), m_go);
      check_eq("pixel_on", int'(pixel_on), exp_pix);
    end
    rst_n      = (rn != 0);
    pixel_x    = 10'(px);
    pixel_y    = 10'(py);
    video_on   = (vo != 0);
    frame_tick = (ft != 0);
    life_lost  = (ll != 0);
    life_gain  = (lg != 0);
    game_reset = (gr != 0);
    #1;
    dx    = px - HUD_X0;
    dy    = py - HUD_Y0;
    ex    = dx & 15;
    ey    = dy & 15;
    slot  = (dx >= 0) ? dx / 16 : -1;
    inreg = (px >= HUD_X0 && py >= HUD_Y0 && dy < 15 && ex < 15 && slot < MAX_LIVES) ? 1 : 0;
    vis   = (m_blink != 0 && ((m_t / BLINK_FRAMES) % 2) == 1) ? 1 : 0;
    lit   = (slot < m_lives || (vis != 0 && slot == m_idx)) ? 1 : 0;
    een   = (vo != 0 && inreg != 0 && lit != 0) ? 1 : 0;
    nxt_pix = rom_f(ex, ey, een) ? 1 : 0;
    if (m_valid != 0) begin
      check_eq("heart_en", int'(heart_en), een);
      check_eq("heart_x", int'(heart_x), ex);
      check_eq("heart_y", int'(heart_y), ey);
    end
    @(posedge clk);
    if (rn == 0) begin
      m_lives = START_LIVES; m_go = 0; m_blink = 0; m_t = 0; m_valid = 1;
      exp_pix = 0;
    end else begin
      exp_pix = nxt_pix;
      lost_ok = (ll != 0 && lg == 0 && m_go == 0) ? 1 : 0;
      gain_ok = (lg != 0 && ll == 0 && m_go == 0) ? 1 : 0;
      if (gr != 0) begin
        m_lives = START_LIVES; m_go = 0; m_blink = 0;
      end else if (lost_ok != 0) begin
        m_lives = m_lives - 1;
        if (m_lives == 0) m_go = 1;
        m_blink = 1; m_t = 0; m_idx = m_lives;
      end else if (gain_ok != 0) begin
        m_lives = (m_lives + 1 > MAX_LIVES) ? MAX_LIVES : m_lives + 1;
        m_blink = 0;
      end else if (m_blink != 0 && ft != 0) begin
        m_t = m_t + 1;
        if (m_t == BLINK_FRAMES * BLINK_TOGGLES) m_blink = 0;
      end
    end
  endtask

  initial begin
    int px, py;
    rst_n = 1'b0; pixel_x = '0; pixel_y = '0; video_on = 1'b0; frame_tick = 1'b0;
    life_lost = 1'b0; life_gain = 1'b0; game_reset = 1'b0;

    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 31, 20, 1, 0, 0, 0, 0);
    cycle(1, 63, 20, 1, 0, 0, 0, 0);
    cycle(1, 23, 20, 1, 0, 0, 0, 0);
    // Hit from 3 lives, then watch slot 2 through the full blink with a tick every cycle.
    cycle(1, 47, 20, 1, 1, 1, 0, 0);
    for (int i = 0; i < 52; i++) cycle(1, 47, 20, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 71, 14, 1, 0, 0, 1, 0);
    cycle(1, 79, 14, 1, 0, 1, 1, 0);
    for (int i = 0; i < 5; i++) cycle(1, 8, 8, 1, 0, 1, 0, 0);
    cycle(1, 8, 8, 1, 1, 0, 1, 0);
    cycle(1, 9, 9, 1, 0, 0, 0, 1);
    // Reset in the middle of a blink on slot 2.
    cycle(1, 47, 20, 1, 0, 1, 0, 0);
    for (int i = 0; i < 20; i++) cycle(1, 55, 15, 1, 1, 0, 0, 0);
    cycle(0, 55, 15, 1, 1, 0, 0, 0);
    cycle(1, 63, 20, 1, 0, 0, 0, 0);

    for (int i = 0; i < 20000; i++) begin
      px = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 110));
      py = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 30));
      cycle(($urandom_range(0, 599) == 0) ? 0 : 1, px, py,
            ($urandom_range(0, 9) == 0) ? 0 : 1,
            ($urandom_range(0, 1) == 0) ? 1 : 0,
            ($urandom_range(0, 29) == 0) ? 1 : 0,
            ($urandom_range(0, 39) == 0) ? 1 : 0,
            ($urandom_range(0, 399) == 0) ? 1 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
